// File: rtl/acc_row_sequencer.sv
// acc_row_sequencer: feeds the multiplier product stream into the shared FP
// accumulator, tags every COLS-th beat with tlast, and captures only the final
// row sums (tlast=1 results) into the result buffer by row index.
// Optional feature macro: ACC_SEQ_ERRCHK_EN enables the sticky err_seq check;
// without it err_seq is tied low.
module acc_row_sequencer #(
  parameter int ROWS   = 6,
  parameter int COLS   = 6,
  parameter int DATA_W = 32,
  localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] s_prod_tdata,
  input  logic              s_prod_tvalid,
  output logic              s_prod_tready,
  output logic [DATA_W-1:0] acc_a_tdata,
  output logic              acc_a_tvalid,
  output logic              acc_a_tlast,
  input  logic              acc_a_tready,
  input  logic [DATA_W-1:0] acc_res_tdata,
  input  logic              acc_res_tvalid,
  input  logic              acc_res_tlast,
  output logic              acc_res_tready,
  output logic              res_wr_en,
  output logic [AW-1:0]     res_wr_addr,
  output logic [DATA_W-1:0] res_wr_data,
  output logic              err_seq
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  // Row counters must be able to hold ROWS itself (all rows issued / done).
  localparam int RW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_ALL  = RW'(ROWS);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_issued_q, row_issued_d;
  logic [RW-1:0] row_done_q, row_done_d;
  logic res_wr_en_q, res_wr_en_d;
  logic [AW-1:0] res_wr_addr_q, res_wr_addr_d;
  logic [DATA_W-1:0] res_wr_data_q, res_wr_data_d;

  logic in_feed;
  logic beat_xfer;
  logic col_wrap;
  logic last_beat;
  logic final_res;
  logic capture;
  logic last_capture;

  assign in_feed   = (state_q == S_FEED);
  assign beat_xfer = in_feed && s_prod_tvalid && acc_a_tready;
  assign col_wrap  = (col_cnt_q == COL_LAST);
  assign last_beat = beat_xfer && col_wrap && (row_issued_q == ROW_LAST);

  // The result port never stalls, so a valid beat is always a handshake.
  assign acc_res_tready = 1'b1;
  assign final_res      = acc_res_tvalid && acc_res_tlast;
  // Saturate at ROWS so a stray extra final sum can never write past the buffer.
  assign capture        = final_res && ((state_q == S_FEED) || (state_q == S_DRAIN))
                          && (row_done_q != ROW_ALL);
  assign last_capture   = capture && (row_done_q == ROW_LAST);

  // FSM next-state: start -> feed all beats -> wait for last row sum -> done pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FEED;
      S_FEED:  if (last_beat) state_d = S_DRAIN;
      S_DRAIN: if (last_capture || (row_done_q == ROW_ALL)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: product path is a gated combinational pass-through in FEED only.
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    acc_a_tvalid  = in_feed && s_prod_tvalid;
    acc_a_tdata   = in_feed ? s_prod_tdata : '0;
    acc_a_tlast   = in_feed && col_wrap;
    s_prod_tready = in_feed && acc_a_tready;
  end

  // Column/row bookkeeping: issue and capture advance independently.
  always_comb begin
    col_cnt_d    = col_cnt_q;
    row_issued_d = row_issued_q;
    row_done_d   = row_done_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        col_cnt_d    = '0;
        row_issued_d = '0;
        row_done_d   = '0;
      end
    end else begin
      if (beat_xfer) begin
        if (col_wrap) begin
          col_cnt_d    = '0;
          row_issued_d = row_issued_q + 1'b1;
        end else begin
          col_cnt_d = col_cnt_q + 1'b1;
        end
      end
      if (capture) begin
        row_done_d = row_done_q + 1'b1;
      end
    end
  end

  // Result buffer write port: one-cycle strobe, address/data hold between writes.
  always_comb begin
    res_wr_en_d   = capture;
    res_wr_addr_d = res_wr_addr_q;
    res_wr_data_d = res_wr_data_q;
    if (capture) begin
      res_wr_addr_d = row_done_q[AW-1:0];
      res_wr_data_d = acc_res_tdata;
    end
  end

  // State and datapath registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      col_cnt_q     <= '0;
      row_issued_q  <= '0;
      row_done_q    <= '0;
      res_wr_en_q   <= 1'b0;
      res_wr_addr_q <= '0;
      res_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      col_cnt_q     <= col_cnt_d;
      row_issued_q  <= row_issued_d;
      row_done_q    <= row_done_d;
      res_wr_en_q   <= res_wr_en_d;
      res_wr_addr_q <= res_wr_addr_d;
      res_wr_data_q <= res_wr_data_d;
    end
  end

  assign res_wr_en   = res_wr_en_q;
  assign res_wr_addr = res_wr_addr_q;
  assign res_wr_data = res_wr_data_q;

`ifdef ACC_SEQ_ERRCHK_EN
  logic err_seq_q, err_seq_d;

  // Sticky flag: a final sum that no issued row accounts for, or one seen in IDLE.
  always_comb begin
    err_seq_d = err_seq_q;
    if (final_res && ((state_q == S_IDLE) || (row_done_q == row_issued_q))) begin
      err_seq_d = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      err_seq_q <= 1'b0;
    end else begin
      err_seq_q <= err_seq_d;
    end
  end

  assign err_seq = err_seq_q;
`else
  assign err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_acc_row_sequencer.sv
// Testbench for acc_row_sequencer (ROWS=2, COLS=3). Drives a product stream,
// models the FP accumulator as a delayed running-sum stream, and checks every
// cycle against expectations derived from the row/column job rules.
module tb_acc_row_sequencer;

  localparam int ROWS   = 2;
  localparam int COLS   = 3;
  localparam int DATA_W = 32;
  localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic              aclk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done;
  logic [DATA_W-1:0] s_prod_tdata = '0;
  logic              s_prod_tvalid = 1'b0;
  logic              s_prod_tready;
  logic [DATA_W-1:0] acc_a_tdata;
  logic              acc_a_tvalid, acc_a_tlast;
  logic              acc_a_tready = 1'b0;
  logic [DATA_W-1:0] acc_res_tdata = '0;
  logic              acc_res_tvalid = 1'b0;
  logic              acc_res_tlast = 1'b0;
  logic              acc_res_tready;
  logic              res_wr_en;
  logic [AW-1:0]     res_wr_addr;
  logic [DATA_W-1:0] res_wr_data;
  logic              err_seq;

  acc_row_sequencer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .reset(reset), .start(start), .busy(busy), .done(done),
    .s_prod_tdata(s_prod_tdata), .s_prod_tvalid(s_prod_tvalid), .s_prod_tready(s_prod_tready),
    .acc_a_tdata(acc_a_tdata), .acc_a_tvalid(acc_a_tvalid), .acc_a_tlast(acc_a_tlast),
    .acc_a_tready(acc_a_tready),
    .acc_res_tdata(acc_res_tdata), .acc_res_tvalid(acc_res_tvalid), .acc_res_tlast(acc_res_tlast),
    .acc_res_tready(acc_res_tready),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .err_seq(err_seq)
  );

  initial forever #5 aclk = ~aclk;

  typedef enum int {P_IDLE, P_FEED, P_DRAIN, P_DONE} phase_t;
  typedef struct {
    logic [31:0] data;
    bit          last;
    int          due;
  } res_t;

  int checks = 0;
  int errors = 0;

  // Job-level reference state
  phase_t      phase = P_IDLE;
  int          prod[$];
  int          pidx = 0;
  int          ncap = 0;
  logic [31:0] exp_sum [ROWS];
  bit          err_exp = 1'b0;
  // Stimulus knobs
  int          rmode = 0;
  bit          vrand = 1'b0;
  bit          partial = 1'b0;
  int          lat = 3;
  bit          start_drv = 1'b0;
  bit          rst_drv = 1'b0;
  bit          pv = 1'b0;
  bit          pv_hold = 1'b0;
  bit          tr = 1'b0;
  int          cyc = 0;
  // FP accumulator model
  res_t        resq[$];
  int          fp_sum = 0;
  // Per-job observations
  logic [31:0] wr_log[$];
  int          wr_seen = 0;
  int          done_seen = 0;
  int          tlast_seen = 0;
  int          job_no = 0;

  // Exact IEEE-754 single encoding of a positive integer below 2^24.
  function automatic logic [31:0] f32(input int n);
    int e;
    int m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (((n >> i) & 1) == 1) e = i;
    m = (n << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the reference at the edge and check registered outputs just after.
  task automatic tick();
    bit          xfer;
    bit          take;
    bit          rlast;
    bit          exp_we;
    bit          exp_feed;
    bit          blast;
    int          exp_addr;
    int          due;
    logic [31:0] pdata;
    phase_t      prev;
`ifdef ACC_SEQ_ERRCHK_EN
    int          issued_before;
`endif
    start = start_drv;
    reset = rst_drv;
    if (!pv_hold) pv = (pidx < prod.size()) && (!vrand || ($urandom_range(0, 3) != 0));
    pdata = pv ? f32(prod[pidx]) : 32'($urandom);
    s_prod_tvalid = pv;
    s_prod_tdata  = pdata;
    case (rmode)
      0:       tr = 1'b1;
      1:       tr = ~tr;
      default: tr = ($urandom_range(0, 1) == 1);
    endcase
    acc_a_tready = tr;
    if (resq.size() > 0 && resq[0].due <= cyc) begin
      acc_res_tvalid = 1'b1;
      acc_res_tdata  = resq[0].data;
      acc_res_tlast  = resq[0].last;
    end else begin
      acc_res_tvalid = 1'b0;
      acc_res_tdata  = 32'($urandom);
      acc_res_tlast  = ($urandom_range(0, 1) == 1);
    end

    @(negedge aclk);
    exp_feed = (phase == P_FEED);
    chk1("s_prod_tready", s_prod_tready, exp_feed ? tr : 1'b0);
    chk1("acc_a_tvalid", acc_a_tvalid, exp_feed ? pv : 1'b0);
    chk1("acc_res_tready", acc_res_tready, 1'b1);
    blast = ((pidx % COLS) == (COLS - 1));
    if (exp_feed && pv) begin
      chk32("acc_a_tdata", acc_a_tdata, pdata);
      chk1("acc_a_tlast", acc_a_tlast, blast);
    end else if (!exp_feed) begin
      chk32("acc_a_tdata_gated", acc_a_tdata, 32'h0);
      chk1("acc_a_tlast_gated", acc_a_tlast, 1'b0);
    end
    xfer  = exp_feed && pv && tr;
    take  = acc_res_tvalid;
    rlast = acc_res_tlast;
`ifdef ACC_SEQ_ERRCHK_EN
    issued_before = pidx / COLS;
`endif

    @(posedge aclk);
    #1;
    cyc++;
    prev = phase;

    if (rst_drv) begin
      phase = P_IDLE;
      err_exp = 1'b0;
      resq.delete();
      fp_sum = 0;
      pv = 1'b0;
      pv_hold = 1'b0;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_res_wr_en", res_wr_en, 1'b0);
      chk32("rst_res_wr_addr", 32'(res_wr_addr), 32'h0);
      chk32("rst_res_wr_data", res_wr_data, 32'h0);
      chk1("rst_err_seq", err_seq, 1'b0);
      chk1("rst_acc_a_tvalid", acc_a_tvalid, 1'b0);
      chk1("rst_acc_a_tlast", acc_a_tlast, 1'b0);
      chk32("rst_acc_a_tdata", acc_a_tdata, 32'h0);
      chk1("rst_s_prod_tready", s_prod_tready, 1'b0);
      return;
    end

    if (take) void'(resq.pop_front());
    pv_hold = pv && !xfer;
    if (xfer) begin
      if (blast) tlast_seen++;
      fp_sum += prod[pidx];
      due = cyc + lat - 1;
      if (resq.size() > 0 && due < resq[$].due) due = resq[$].due;
      if (blast) begin
        resq.push_back('{data: f32(fp_sum), last: 1'b1, due: due});
        fp_sum = 0;
      end else if (partial) begin
        resq.push_back('{data: f32(fp_sum), last: 1'b0, due: due});
      end
      pidx++;
    end

`ifdef ACC_SEQ_ERRCHK_EN
    if (take && rlast && (prev == P_IDLE || ncap == issued_before)) err_exp = 1'b1;
`endif

    case (prev)
      P_IDLE:  if (start_drv) phase = P_FEED;
      P_FEED:  if (xfer && pidx == ROWS * COLS) phase = P_DRAIN;
      P_DONE:  phase = P_IDLE;
      default: ;
    endcase

    exp_we = 1'b0;
    exp_addr = 0;
    if ((prev == P_FEED || prev == P_DRAIN) && take && rlast) begin
      exp_we = 1'b1;
      exp_addr = ncap;
      ncap++;
      if (prev == P_DRAIN && ncap == ROWS) phase = P_DONE;
    end

    chk1("res_wr_en", res_wr_en, exp_we);
    if (exp_we && exp_addr < ROWS) begin
      chk32("res_wr_addr", 32'(res_wr_addr), 32'(exp_addr));
      chk32("res_wr_data", res_wr_data, exp_sum[exp_addr]);
    end
    if (res_wr_en === 1'b1) begin
      wr_seen++;
      wr_log.push_back(res_wr_data);
      $display("[cycle %0d] write row %0d data %h", cyc, res_wr_addr, res_wr_data);
    end
    if (done === 1'b1) done_seen++;
    chk1("done", done, phase == P_DONE);
    chk1("busy", busy, phase != P_IDLE);
    chk1("err_seq", err_seq, err_exp);
  endtask

  // Runs one job over the current prod queue. mid_start: loop cycle at which a
  // spurious start is pulsed (-1 none); rst_beats: assert reset once this many
  // beats have transferred (-1 none).
  task automatic run_job(input int mid_start, input int rst_beats);
    int budget;
    int s;
    bit did_rst;
    budget = 0;
    did_rst = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      s = 0;
      for (int c = 0; c < COLS; c++) s += prod[r * COLS + c];
      exp_sum[r] = f32(s);
    end
    pidx = 0;
    ncap = 0;
    fp_sum = 0;
    pv_hold = 1'b0;
    wr_log.delete();
    wr_seen = 0;
    done_seen = 0;
    tlast_seen = 0;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    while (phase != P_IDLE && budget < 400) begin
      start_drv = (budget == mid_start);
      rst_drv = (rst_beats >= 0 && pidx == rst_beats && phase == P_FEED);
      if (rst_drv) did_rst = 1'b1;
      tick();
      budget++;
      rst_drv = 1'b0;
    end
    start_drv = 1'b0;
    reset = 1'b0;
    chk1("job_within_budget", budget < 400, 1'b1);
    if (!did_rst) begin
      chk32("write_count", 32'(wr_seen), 32'(ROWS));
      chk32("done_pulses", 32'(done_seen), 32'd1);
      chk32("tlast_beats", 32'(tlast_seen), 32'(ROWS));
    end
    $display("job %0d: beats %0d, writes %0d, cycles %0d%s", job_no, pidx, wr_seen, budget,
             did_rst ? " (reset mid-job)" : "");
    job_no++;
  endtask

  initial begin
    // Reset state with a valid product waiting at the input
    prod = '{7};
    rst_drv = 1'b1;
    repeat (3) tick();
    rst_drv = 1'b0;
    reset = 1'b0;

    // Basic job
    prod = '{1, 2, 3, 4, 5, 6};
    rmode = 0; vrand = 1'b0; partial = 1'b0; lat = 3;
    run_job(-1, -1);
    chk32("basic_row0", (wr_log.size() > 0) ? wr_log[0] : 32'hx, 32'h40C0_0000);
    chk32("basic_row1", (wr_log.size() > 1) ? wr_log[1] : 32'hx, 32'h4170_0000);

    // Backpressure: tready toggles every cycle
    rmode = 1;
    run_job(-1, -1);
    chk32("bp_row0", (wr_log.size() > 0) ? wr_log[0] : 32'hx, 32'h40C0_0000);
    chk32("bp_row1", (wr_log.size() > 1) ? wr_log[1] : 32'hx, 32'h4170_0000);

    // Partial sums emitted per beat
    rmode = 0; partial = 1'b1; lat = 2;
    run_job(-1, -1);
    chk32("partial_row1", (wr_log.size() > 1) ? wr_log[1] : 32'hx, 32'h4170_0000);
    partial = 1'b0; lat = 3;

    // Spurious start during FEED
    run_job(2, -1);

    // Reset after beat 2, then a fresh job
    run_job(-1, 2);
    run_job(-1, -1);
    chk32("fresh_row0", (wr_log.size() > 0) ? wr_log[0] : 32'hx, 32'h40C0_0000);

    // Stray final sum injected in IDLE
    prod.delete();
    pidx = 0;
    resq.push_back('{data: 32'h3F81_0000, last: 1'b1, due: cyc});
    tick();
    tick();
    tick();
    prod = '{1, 2, 3, 4, 5, 6};
    run_job(-1, -1);
    chk32("err_job_row1", (wr_log.size() > 1) ? wr_log[1] : 32'hx, 32'h4170_0000);
    rst_drv = 1'b1;
    tick();
    rst_drv = 1'b0;
    reset = 1'b0;

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      prod.delete();
      for (int k = 0; k < ROWS * COLS; k++) prod.push_back($urandom_range(1, 1000));
      rmode = 2;
      vrand = 1'b1;
      partial = ($urandom_range(0, 1) == 1);
      lat = $urandom_range(1, 4);
      run_job($urandom_range(0, 12), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
